// File: rtl/la_pkg.sv
// Shared types and defaults for the logic-analyzer trigger/readout stage.
// Holds the FSM state enum, default sizes and the pointer-width helper.
package la_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_POST,
    ST_READOUT
  } la_state_t;

  localparam int LA_NUM_CHANNELS = 8;
  localparam int LA_DEPTH        = 16;
  localparam int LA_PRE_TRIGGER  = 4;

  function automatic int la_ptr_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/la_sample_ram.sv
// Capture history: DEPTH x W register array, sync write, async read, no reset.
// Ports: clk, we_i/waddr_i/wdata_i write port, raddr_i -> rdata_o read port.
module la_sample_ram #(
  parameter int W     = 8,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/la_trigger_readout.sv
// Trigger/capture/readout stage: circular sample history, masked pattern
// trigger, fixed pre/post window streamed oldest-first on valid/ready.
// Ports: clk, reset (sync, active-high), sample_valid/sample_data in,
// trig_mask/trig_value, arm, abort, out_valid/out_ready/out_data/out_last,
// busy, triggered. Define LA_EDGE_TRIGGER_EN for rising-into-pattern trigger.
module la_trigger_readout
  import la_pkg::*;
#(
  parameter int NUM_CHANNELS = LA_NUM_CHANNELS,
  parameter int DEPTH        = LA_DEPTH,
  parameter int PRE_TRIGGER  = LA_PRE_TRIGGER
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    sample_valid,
  input  logic [NUM_CHANNELS-1:0] sample_data,
  input  logic [NUM_CHANNELS-1:0] trig_mask,
  input  logic [NUM_CHANNELS-1:0] trig_value,
  input  logic                    arm,
  input  logic                    abort,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [NUM_CHANNELS-1:0] out_data,
  output logic                    out_last,
  output logic                    busy,
  output logic                    triggered
);

  localparam int PW     = la_ptr_w(DEPTH);
  localparam int POST_N = DEPTH - PRE_TRIGGER - 1;

  localparam logic [PW-1:0] ONE       = PW'(1);
  localparam logic [PW-1:0] PRE_C     = PW'(PRE_TRIGGER);
  localparam logic [PW-1:0] POST_LAST = PW'((POST_N == 0) ? 0 : POST_N - 1);
  localparam logic [PW-1:0] WORD_LAST = PW'(DEPTH - 1);
  localparam logic [PW-1:0] WORD_PEN  = PW'(DEPTH - 2);

  la_state_t     state_q;
  logic [PW-1:0] wp_q;
  logic [PW-1:0] rp_q;
  logic [PW-1:0] pre_cnt_q;
  logic [PW-1:0] post_cnt_q;
  logic [PW-1:0] wcnt_q;
  logic          out_valid_q;
  logic          out_last_q;
  logic          busy_q;
  logic          trig_q;
`ifdef LA_EDGE_TRIGGER_EN
  logic          prev_seen_q;
  logic          prev_match_q;
`endif

  logic          match;
  logic          eligible;
  logic          fire;
  logic          capturing;
  logic          wr_en;
  logic [PW-1:0] wp_d;

  assign match     = ((sample_data ^ trig_value) & trig_mask) == '0;
  assign eligible  = pre_cnt_q == PRE_C;
  assign capturing = (state_q == ST_ARMED) || (state_q == ST_POST);
  assign wr_en     = capturing & sample_valid & ~abort & ~reset;
  assign wp_d      = wp_q + ONE;

`ifdef LA_EDGE_TRIGGER_EN
  // Only a sample that enters the pattern fires; the first sample after
  // arm has no predecessor and so can never fire.
  assign fire = eligible & match & prev_seen_q & ~prev_match_q;
`else
  assign fire = eligible & match;
`endif

  la_sample_ram #(
    .W     (NUM_CHANNELS),
    .DEPTH (DEPTH),
    .AW    (PW)
  ) u_ram (
    .clk     (clk),
    .we_i    (wr_en),
    .waddr_i (wp_q),
    .wdata_i (sample_data),
    .raddr_i (rp_q),
    .rdata_o (out_data)
  );

  always_ff @(posedge clk) begin
    if (reset || abort) begin
      state_q      <= ST_IDLE;
      wp_q         <= '0;
      rp_q         <= '0;
      pre_cnt_q    <= '0;
      post_cnt_q   <= '0;
      wcnt_q       <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      busy_q       <= 1'b0;
      trig_q       <= 1'b0;
`ifdef LA_EDGE_TRIGGER_EN
      prev_seen_q  <= 1'b0;
      prev_match_q <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          pre_cnt_q  <= '0;
          post_cnt_q <= '0;
          wcnt_q     <= '0;
`ifdef LA_EDGE_TRIGGER_EN
          prev_seen_q <= 1'b0;
`endif
          if (arm) begin
            state_q <= ST_ARMED;
            busy_q  <= 1'b1;
          end
        end
        ST_ARMED: begin
          if (sample_valid) begin
            wp_q <= wp_d;
            if (!eligible) pre_cnt_q <= pre_cnt_q + ONE;
`ifdef LA_EDGE_TRIGGER_EN
            prev_seen_q  <= 1'b1;
            prev_match_q <= match;
`endif
            if (fire) begin
              trig_q <= 1'b1;
              if (POST_N == 0) begin
                // Trigger sample closes the window; wp_d is the oldest.
                state_q     <= ST_READOUT;
                rp_q        <= wp_d;
                out_valid_q <= 1'b1;
                out_last_q  <= 1'b0;
              end else begin
                state_q <= ST_POST;
              end
            end
          end
        end
        ST_POST: begin
          if (sample_valid) begin
            wp_q       <= wp_d;
            post_cnt_q <= post_cnt_q + ONE;
            if (post_cnt_q == POST_LAST) begin
              state_q     <= ST_READOUT;
              rp_q        <= wp_d;
              out_valid_q <= 1'b1;
              out_last_q  <= 1'b0;
            end
          end
        end
        ST_READOUT: begin
          if (out_ready) begin
            rp_q       <= rp_q + ONE;
            wcnt_q     <= wcnt_q + ONE;
            out_last_q <= (wcnt_q == WORD_PEN);
            if (wcnt_q == WORD_LAST) begin
              state_q     <= ST_IDLE;
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              busy_q      <= 1'b0;
              trig_q      <= 1'b0;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign triggered = trig_q;

endmodule

// File: tb/tb_la_trigger_readout.sv
// Self-checking bench for la_trigger_readout: queue-based window model,
// per-cycle compare process, directed literal windows and random traffic.
module tb_la_trigger_readout;

  localparam int NC    = 8;
  localparam int DEPTH = 16;
  localparam int PRE   = 4;

  logic          clk;
  logic          reset;
  logic          sample_valid;
  logic [NC-1:0] sample_data;
  logic [NC-1:0] trig_mask;
  logic [NC-1:0] trig_value;
  logic          arm;
  logic          abort;
  logic          out_valid;
  logic          out_ready;
  logic [NC-1:0] out_data;
  logic          out_last;
  logic          busy;
  logic          triggered;

  la_trigger_readout #(
    .NUM_CHANNELS (NC),
    .DEPTH        (DEPTH),
    .PRE_TRIGGER  (PRE)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .trig_mask    (trig_mask),
    .trig_value   (trig_value),
    .arm          (arm),
    .abort        (abort),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_last     (out_last),
    .busy         (busy),
    .triggered    (triggered)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase of the capture, list of valid samples since arm,
  // index of the trigger sample in that list, and the resulting window.
  localparam int M_IDLE = 0;
  localparam int M_CAP  = 1;
  localparam int M_READ = 2;

  int            m_phase = M_IDLE;
  int            m_trig  = -1;
  int            m_widx  = 0;
  logic [NC-1:0] hist[$];
  bit            mt[$];
  logic [NC-1:0] win[DEPTH];

  always @(posedge clk) begin
    if (reset || abort) begin
      m_phase = M_IDLE;
    end else begin
      case (m_phase)
        M_IDLE: begin
          if (arm) begin
            m_phase = M_CAP;
            hist.delete();
            mt.delete();
            m_trig = -1;
          end
        end
        M_CAP: begin
          if (sample_valid) begin
            bit mm;
            int idx;
            mm = (((sample_data ^ trig_value) & trig_mask) == 0);
            hist.push_back(sample_data);
            mt.push_back(mm);
            idx = hist.size() - 1;
            if (m_trig < 0 && idx >= PRE && mm) begin
`ifdef LA_EDGE_TRIGGER_EN
              if (idx > 0 && !mt[idx-1]) m_trig = idx;
`else
              m_trig = idx;
`endif
            end
            if (m_trig >= 0 && hist.size() == m_trig + DEPTH - PRE) begin
              for (int k = 0; k < DEPTH; k++) win[k] = hist[m_trig - PRE + k];
              m_phase = M_READ;
              m_widx  = 0;
            end
          end
        end
        M_READ: begin
          if (out_ready) begin
            m_widx++;
            if (m_widx == DEPTH) m_phase = M_IDLE;
          end
        end
        default: m_phase = M_IDLE;
      endcase
    end
  end

  bit cmp_en = 1'b0;

  always @(negedge clk) begin
    if (cmp_en && !reset) begin
      chk("busy", 32'(busy), 32'(m_phase != M_IDLE));
      chk("triggered", 32'(triggered),
          32'((m_phase == M_CAP && m_trig >= 0) || m_phase == M_READ));
      chk("out_valid", 32'(out_valid), 32'(m_phase == M_READ));
      chk("out_last", 32'(out_last),
          32'(m_phase == M_READ && m_widx == DEPTH - 1));
      if (m_phase == M_READ) chk("out_data", 32'(out_data), 32'(win[m_widx]));
    end
  end

  task automatic drive(input bit v, input logic [NC-1:0] d, input bit a,
                       input bit ab, input bit r);
    @(negedge clk);
    sample_valid = v;
    sample_data  = d;
    arm          = a;
    abort        = ab;
    out_ready    = r;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 8'h00, 0, 0, 0);
  endtask

  task automatic send(input logic [NC-1:0] d, input bit gap);
    drive(1, d, 0, 0, 0);
    if (gap) drive(0, 8'hFF, 0, 0, 0);
  endtask

  logic [NC-1:0] got[DEPTH];
  bit            lst[DEPTH];

  // mode 0: ready held high; mode 1: ready pattern 1,0,0,1
  task automatic readout(input int mode, output int n);
    n = 0;
    for (int c = 0; c < 80 && n < DEPTH; c++) begin
      bit r;
      r = (mode == 0) ? 1'b1 : ((c % 4 == 0) || (c % 4 == 3));
      drive(0, 8'h00, 0, 0, r);
      if (out_valid && r) begin
        got[n] = out_data;
        lst[n] = out_last;
        n++;
      end
    end
  endtask

  task automatic chk_win(input string tag, input int n,
                         input logic [NC-1:0] w0, input logic [NC-1:0] w3,
                         input logic [NC-1:0] w4, input logic [NC-1:0] w15);
    int nl;
    nl = 0;
    chk({tag, "_words"}, 32'(n), 32'(DEPTH));
    chk({tag, "_w0"}, 32'(got[0]), 32'(w0));
    chk({tag, "_w3"}, 32'(got[3]), 32'(w3));
    chk({tag, "_w4"}, 32'(got[4]), 32'(w4));
    chk({tag, "_w15"}, 32'(got[15]), 32'(w15));
    for (int i = 0; i < DEPTH; i++) nl += int'(lst[i]);
    chk({tag, "_last_cnt"}, 32'(nl), 32'd1);
    chk({tag, "_last15"}, 32'(lst[15]), 32'd1);
    drive(0, 8'h00, 0, 0, 0);
    chk({tag, "_busy_drop"}, 32'(busy), 32'd0);
  endtask

  // 6 non-matching samples, 0x01 as the 7th, then 11 post samples.
  task automatic cap_basic(input bit gap);
    drive(0, 8'h00, 1, 0, 0);
    for (int i = 0; i < 6; i++) send(8'(8'h10 + 2 * i), gap);
    send(8'h01, gap);
    for (int k = 0; k < 11; k++) send(8'(8'h20 + 2 * k), gap);
  endtask

  initial begin
    int n;
    reset        = 1'b1;
    sample_valid = 1'b0;
    sample_data  = '0;
    trig_mask    = 8'h01;
    trig_value   = 8'h01;
    arm          = 1'b0;
    abort        = 1'b0;
    out_ready    = 1'b0;
    idle(3);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_trig", 32'(triggered), 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
    @(negedge clk);
    reset  = 1'b0;
    cmp_en = 1'b1;
    idle(2);

    // Basic capture, ready held high.
    cap_basic(0);
    readout(0, n);
    chk_win("basic", n, 8'h14, 8'h1A, 8'h01, 8'h34);

    // Same capture with ready toggling.
    cap_basic(0);
    readout(1, n);
    chk_win("stall", n, 8'h14, 8'h1A, 8'h01, 8'h34);

    // Half-rate valid; invalid cycles carry matching junk.
    cap_basic(1);
    readout(0, n);
    chk_win("gap", n, 8'h14, 8'h1A, 8'h01, 8'h34);

    // Pattern on samples 1-3 is ineligible; 6th sample triggers.
    drive(0, 8'h00, 1, 0, 0);
    send(8'h03, 0); send(8'h05, 0); send(8'h07, 0);
    send(8'h08, 0); send(8'h0A, 0); send(8'h0B, 0);
    for (int k = 0; k < 11; k++) send(8'(8'h40 + 2 * k), 0);
    readout(0, n);
    chk_win("early", n, 8'h05, 8'h0A, 8'h0B, 8'h54);

    // Abort mid-POST.
    drive(0, 8'h00, 1, 0, 0);
    for (int i = 0; i < 6; i++) send(8'(8'h10 + 2 * i), 0);
    send(8'h01, 0);
    for (int k = 0; k < 3; k++) send(8'(8'h20 + 2 * k), 0);
    chk("post_trig", 32'(triggered), 32'd1);
    drive(0, 8'h00, 1, 1, 0);
    drive(0, 8'h00, 0, 0, 0);
    chk("abort_post_busy", 32'(busy), 32'd0);
    chk("abort_post_valid", 32'(out_valid), 32'd0);
    cap_basic(0);
    readout(0, n);
    chk_win("rearm", n, 8'h14, 8'h1A, 8'h01, 8'h34);

    // Abort mid-READOUT with ready high.
    cap_basic(0);
    for (int i = 0; i < 5; i++) drive(0, 8'h00, 0, 0, 1);
    drive(0, 8'h00, 0, 1, 1);
    drive(0, 8'h00, 0, 0, 0);
    chk("abort_rd_busy", 32'(busy), 32'd0);
    chk("abort_rd_valid", 32'(out_valid), 32'd0);
    cap_basic(0);
    readout(0, n);
    chk_win("rearm2", n, 8'h14, 8'h1A, 8'h01, 8'h34);

    // Pattern held from arm, dropped at idx 8, re-rises at idx 9.
    drive(0, 8'h00, 1, 0, 0);
    for (int i = 0; i < 8; i++) send(8'(8'h11 + 2 * i), 0);
    send(8'h40, 0);
    send(8'h55, 0);
    for (int k = 0; k < 11; k++) send(8'(8'h60 + 2 * k), 0);
    readout(0, n);
`ifdef LA_EDGE_TRIGGER_EN
    chk_win("edge", n, 8'h1B, 8'h40, 8'h55, 8'h74);
`else
    chk_win("level", n, 8'h11, 8'h17, 8'h19, 8'h6A);
`endif

    // Random traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      if (c % 250 == 0) begin
        @(negedge clk);
        trig_mask  = 8'($urandom_range(0, 7));
        trig_value = 8'($urandom);
      end
      drive(($urandom % 4) != 0, 8'($urandom), ($urandom % 6) == 0,
            ($urandom % 400) == 0, ($urandom % 3) != 0);
    end
    idle(2);
    abort = 1'b1;
    idle(1);
    abort = 1'b0;
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/la_trigger_readout.md
# la_trigger_readout

Downstream stage of the 8-channel sample shifter. Consumes its per-cycle channel word and holds a circular history of the most recent samples. When armed, it waits for a masked trigger pattern, captures a fixed pre/post-trigger window, then streams that window out oldest-first over a valid/ready byte interface. This interface feeds the host-side readout path.

## Interface
- NUM_CHANNELS, 8, channels per sample word (= out_data width)
- DEPTH, 16, samples per capture window; power of 2, ≥ 2
- PRE_TRIGGER, 4, samples kept before the trigger sample; 0 ≤ PRE_TRIGGER < DEPTH

- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- sample_valid  in  1  sample_data is a new sample this cycle
- sample_data  in  NUM_CHANNELS  one bit per channel
- trig_mask  in  NUM_CHANNELS  1 = channel participates in trigger
- trig_value  in  NUM_CHANNELS  required level on masked channels
- arm  in  1  start capture (sampled in IDLE only)
- abort  in  1  return to IDLE from any state
- out_valid  out  1  out_data holds a readout word
- out_ready  in  1  consumer accepts word
- out_data  out  NUM_CHANNELS  readout word
- out_last  out  1  final word of window, qualified by out_valid
- busy  out  1  state ≠ IDLE
- triggered  out  1  state ∈ {POST, READOUT}

## Operation
- States: IDLE, ARMED, POST, READOUT (enum in package).
- IDLE: no writes. arm=1 → ARMED. Clears pre-count and post-count; in edge mode also clears prev-valid.
- ARMED: each sample_valid writes sample_data to mem[wp], wp += 1 mod DEPTH, pre-count saturates at PRE_TRIGGER.
  - Match = ((sample_data ^ trig_value) & trig_mask) == 0.
  - Match is evaluated only on sample_valid and only when pre-count == PRE_TRIGGER before this sample.
  - Trigger sample is written. If DEPTH−PRE_TRIGGER−1 = 0 → READOUT; else → POST.
- trig_mask = 0 triggers on the first eligible sample.
- POST: writes continue; after DEPTH−PRE_TRIGGER−1 further valid samples → READOUT.
  - rp is loaded with the wp value after the final write, i.e. the oldest sample.
- READOUT: out_valid=1, out_data=mem[rp] (asynchronous read).
  - Handshake = out_valid & out_ready: rp += 1 mod DEPTH, word count += 1.
  - out_last=1 when word count = DEPTH−1. Handshake on the last word → IDLE.
  - sample_valid is ignored in READOUT.
- The trigger sample appears as word index PRE_TRIGGER (0-based) of the window.
- arm while busy: ignored. abort has priority over arm, trigger and handshake.
- sample_valid low: no write, no trigger evaluation, counters hold.

## Timing
- Reset and abort: the next cycle has state=IDLE, out_valid=0, out_last=0, busy=0, triggered=0, wp=rp=0. out_data is don't-care while out_valid=0. Memory contents are not cleared.
- arm at edge N → busy=1 at N+1. The first sample written is the one presented at N+1 or later.
- Trigger sample accepted at edge T → triggered=1 from T+1.
- Final capture write at edge F → out_valid=1 from F+1.
- Readout throughput: 1 word/cycle with out_ready held high; DEPTH consecutive valid cycles, no bubbles.
- out_valid stays high and out_data/out_last stay stable while out_ready=0.
- Last handshake at edge L → out_valid=0, busy=0 at L+1. arm at L+1 is accepted.

## Configuration
- LA_EDGE_TRIGGER_EN defined:
  - Trigger requires match on the current valid sample AND no match on the previous valid sample (rising into the pattern).
  - prev-valid is cleared on arm, so the first sample after arm cannot trigger.
- Undefined: level trigger, i.e. match on the current eligible sample alone.

## Structure
- Package la_pkg holds:
  - the state enum la_state_t
  - default localparams LA_NUM_CHANNELS=8, LA_DEPTH=16, LA_PRE_TRIGGER=4
  - the pointer-width function clog2-based
- Sub-module la_sample_ram: DEPTH×NUM_CHANNELS register array, 1 sync write port, 1 async read port, no reset.

## Test plan
- Default params, level mode, mask=0x01, value=0x01; samples 0x10,0x12,…; 0x01 is sent as the 7th sample after arm → 16 words read; word 4 = 0x01; words 0–3 = 4 preceding samples; out_last only on word 15.
- Trigger pattern present on samples 1–3 after arm (pre-count < 4) → no trigger. A later match → triggers; window word 4 = that sample.
- Readout with out_ready toggling 1,0,0,1 → out_data/out_last stable during stalls; exactly 16 handshakes; busy drops the cycle after the last.
- abort asserted mid-POST and mid-READOUT → state IDLE, out_valid=0 next cycle. A fresh arm then captures correctly.
- sample_valid low every other cycle during ARMED/POST → window contains only the valid samples, in order.
- With LA_EDGE_TRIGGER_EN, pattern held high from arm → no trigger until it drops and re-rises; window word 4 = the re-rise sample.
